// File: rtl/spi_pwm_master_if.sv
// Bus bundle for spi_pwm_master: host-side frame handshake plus the SPI pins.
//   start    host -> master  one-cycle frame request
//   tx_data  host -> master  frame to send, latched on accepted start
//   busy     master -> host  frame in progress (setup through gap)
//   done     master -> host  one-cycle pulse, rx_data valid from this cycle
//   rx_data  master -> host  last received frame
//   sclk     master -> slave SPI clock, idles low
//   mosi     master -> slave serial data out
//   miso     slave -> master serial data in
//   cs       master -> slave active-low chip select
interface spi_pwm_master_if #(
  parameter int unsigned FRAME_W = 16
);
  logic               start;
  logic [FRAME_W-1:0] tx_data;
  logic               busy;
  logic               done;
  logic [FRAME_W-1:0] rx_data;
  logic               sclk;
  logic               mosi;
  logic               miso;
  logic               cs;

  modport master (
    input  start, tx_data, miso,
    output busy, done, rx_data, sclk, mosi, cs
  );

  modport slave (
    output start, tx_data, miso,
    input  busy, done, rx_data, sclk, mosi, cs
  );
endinterface

// File: rtl/spi_pwm_master.sv
// SPI mode-0 initiator (CPOL=0, CPHA=0, MSB first) for the SPI-PWM slave.
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous active-high reset
//   bus  spi_pwm_master_if.master: start/tx_data/busy/done/rx_data handshake
//        and sclk/mosi/miso/cs pins
// Every phase (setup, sclk high, sclk low, hold, gap) lasts CLK_DIV clocks.
// All outputs are registered.
module spi_pwm_master #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned FRAME_W = 16
) (
  input logic               clk,
  input logic               rst,
  spi_pwm_master_if.master  bus
);

  localparam int unsigned         BcntW   = $clog2(FRAME_W);
  localparam logic [7:0]          DivLast = 8'(CLK_DIV - 1);
  localparam logic [BcntW-1:0]    BitLast = BcntW'(FRAME_W - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StHigh,
    StLow,
    StHold,
    StGap
  } state_e;

  state_e             state_q, state_d;
  logic [7:0]         dcnt_q, dcnt_d;
  logic [BcntW-1:0]   bcnt_q, bcnt_d;
  logic [FRAME_W-1:0] tx_sh_q, tx_sh_d;
  logic [FRAME_W-1:0] rx_sh_q, rx_sh_d;
  logic [FRAME_W-1:0] rx_data_q, rx_data_d;
  logic               sclk_q, sclk_d;
  logic               mosi_q, mosi_d;
  logic               cs_q, cs_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               div_last;

  assign div_last = (dcnt_q == DivLast);

  always_comb begin
    state_d   = state_q;
    dcnt_d    = div_last ? 8'd0 : dcnt_q + 8'd1;
    bcnt_d    = bcnt_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    cs_d      = cs_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        dcnt_d = 8'd0;
        if (bus.start) begin
          state_d = StSetup;
          tx_sh_d = bus.tx_data;
          mosi_d  = bus.tx_data[FRAME_W-1];
          cs_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      StSetup: begin
        if (div_last) begin
          state_d = StHigh;
          sclk_d  = 1'b1;
          bcnt_d  = '0;
        end
      end
      StHigh: begin
        if (div_last) begin
          // miso sampled late in the high phase to give the slave's
          // synchronizer the whole phase to settle.
          rx_sh_d = {rx_sh_q[FRAME_W-2:0], bus.miso};
          sclk_d  = 1'b0;
          if (bcnt_q == BitLast) begin
            state_d = StHold;
          end else begin
            state_d = StLow;
            tx_sh_d = tx_sh_q << 1;
            mosi_d  = tx_sh_q[FRAME_W-2];
          end
        end
      end
      StLow: begin
        if (div_last) begin
          state_d = StHigh;
          sclk_d  = 1'b1;
          bcnt_d  = bcnt_q + 1'b1;
        end
      end
      StHold: begin
        if (div_last) begin
          state_d   = StGap;
          cs_d      = 1'b1;
          mosi_d    = 1'b0;
          done_d    = 1'b1;
          rx_data_d = rx_sh_q;
        end
      end
      StGap: begin
        // Gap keeps cs high long enough for the oversampling slave.
        if (div_last) begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      dcnt_q    <= 8'd0;
      bcnt_q    <= '0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      cs_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dcnt_q    <= dcnt_d;
      bcnt_q    <= bcnt_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      cs_q      <= cs_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.sclk    = sclk_q;
  assign bus.mosi    = mosi_q;
  assign bus.cs      = cs_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rx_data = rx_data_q;

endmodule

// File: tb/tb_spi_pwm_master.sv
// Self-checking bench for spi_pwm_master: one instance at CLK_DIV=4 (loopback
// or a behavioural mode-0 slave) and one at CLK_DIV=2 (loopback, back-to-back).
module tb_spi_pwm_master;

  localparam int unsigned FW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_pwm_master_if #(.FRAME_W(FW)) a_if ();
  spi_pwm_master_if #(.FRAME_W(FW)) b_if ();

  spi_pwm_master #(.CLK_DIV(4), .FRAME_W(FW)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if)
  );

  spi_pwm_master #(.CLK_DIV(2), .FRAME_W(FW)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [FW-1:0] exp_a[$];
  logic [FW-1:0] exp_b[$];

  // Behavioural mode-0 slave on instance A.
  logic          loopback = 1'b1;
  logic [FW-1:0] slave_word = '0;
  logic [FW-1:0] slv_tx = '0;
  logic [FW-1:0] slv_rx = '0;
  logic          slv_cs_p = 1'b1;
  logic          slv_sclk_p = 1'b0;

  assign a_if.miso = loopback ? a_if.mosi : slv_tx[FW-1];
  assign b_if.miso = b_if.mosi;

  always @(posedge clk) begin
    #1;
    if (slv_cs_p && !a_if.cs) slv_tx = slave_word;
    if (!a_if.cs && a_if.sclk && !slv_sclk_p) slv_rx = {slv_rx[FW-2:0], a_if.mosi};
    if (!a_if.cs && !a_if.sclk && slv_sclk_p) slv_tx = slv_tx << 1;
    slv_cs_p   = a_if.cs;
    slv_sclk_p = a_if.sclk;
  end

  // Frame monitor for A.
  logic mon_en = 1'b0;
  int   a_busy_cnt = 0, a_cs_cnt = 0, a_rise_cnt = 0, a_done_cnt = 0;
  int   a_done_total = 0, mosi_viol = 0;
  logic a_sclk_p = 1'b0, a_mosi_p = 1'b0, a_busy_p = 1'b0, a_done_p = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (a_if.busy) a_busy_cnt++;
      if (!a_if.cs) a_cs_cnt++;
      if (a_if.sclk && !a_sclk_p) a_rise_cnt++;
      if ((a_if.mosi !== a_mosi_p) && a_if.sclk) mosi_viol++;
      if (a_if.done) begin
        a_done_cnt++;
        check("a_done_width", a_done_p, 1'b0);
        check("a_cs_low_at_done", a_cs_cnt, 132);
        check("a_sb_has_entry", exp_a.size() > 0, 1'b1);
        if (exp_a.size() > 0) check("a_rx_data", a_if.rx_data, exp_a.pop_front());
      end
      if (a_busy_p && !a_if.busy) begin
        check("a_busy_cycles", a_busy_cnt, 136);
        check("a_sclk_rises", a_rise_cnt, 16);
        check("a_done_pulses", a_done_cnt, 1);
        check("a_mosi_stable_high", mosi_viol, 0);
        a_busy_cnt = 0; a_cs_cnt = 0; a_rise_cnt = 0; a_done_cnt = 0;
      end
    end else begin
      a_busy_cnt = 0; a_cs_cnt = 0; a_rise_cnt = 0; a_done_cnt = 0;
    end
    if (a_if.done) a_done_total++;
    a_sclk_p = a_if.sclk;
    a_mosi_p = a_if.mosi;
    a_busy_p = a_if.busy;
    a_done_p = a_if.done;
  end

  // Frame monitor for B.
  int   b_busy_cnt = 0, b_cs_hi_cnt = 0, b_frames = 0;
  logic b_busy_p = 1'b0, b_cs_p = 1'b1;

  always @(negedge clk) begin
    if (!rst) begin
      if (b_if.busy) b_busy_cnt++;
      if (b_if.cs) b_cs_hi_cnt++;
      if (b_cs_p && !b_if.cs) begin
        if (b_frames > 0) check("b_cs_gap_ge2", b_cs_hi_cnt >= 2, 1'b1);
        b_cs_hi_cnt = 0;
      end
      if (b_if.done) begin
        b_frames++;
        check("b_sb_has_entry", exp_b.size() > 0, 1'b1);
        if (exp_b.size() > 0) check("b_rx_data", b_if.rx_data, exp_b.pop_front());
      end
      if (b_busy_p && !b_if.busy) begin
        check("b_busy_cycles", b_busy_cnt, 68);
        b_busy_cnt = 0;
      end
    end
    b_busy_p = b_if.busy;
    b_cs_p   = b_if.cs;
  end

  task automatic wait_idle_a();
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!a_if.busy) return;
    end
    check("a_idle_timeout", a_if.busy, 1'b0);
  endtask

  task automatic wait_idle_b();
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!b_if.busy) return;
    end
    check("b_idle_timeout", b_if.busy, 1'b0);
  endtask

  task automatic send_a(input logic [FW-1:0] d, input logic [FW-1:0] e);
    wait_idle_a();
    @(negedge clk);
    a_if.start   = 1'b1;
    a_if.tx_data = d;
    exp_a.push_back(e);
    @(negedge clk);
    a_if.start = 1'b0;
    wait_idle_a();
  endtask

  initial begin
    int saved_done;
    int rises;
    logic sclk_seen;

    rst = 1'b1;
    a_if.start = 1'b0; a_if.tx_data = '0;
    b_if.start = 1'b0; b_if.tx_data = '0;
    repeat (3) @(negedge clk);

    check("rst_cs", a_if.cs, 1'b1);
    check("rst_sclk", a_if.sclk, 1'b0);
    check("rst_mosi", a_if.mosi, 1'b0);
    check("rst_busy", a_if.busy, 1'b0);
    check("rst_done", a_if.done, 1'b0);
    check("rst_rx_data", a_if.rx_data, 0);
    rst = 1'b0;
    mon_en = 1'b1;

    // Loopback frame.
    send_a(16'hA55A, 16'hA55A);

    // Behavioural slave returns a different word.
    loopback   = 1'b0;
    slave_word = 16'h3C96;
    send_a(16'h8107, 16'h3C96);
    check("slave_captured", slv_rx, 16'h8107);
    loopback = 1'b1;

    // start hammered with changing tx_data during a frame.
    @(negedge clk);
    a_if.start   = 1'b1;
    a_if.tx_data = 16'h5AC3;
    exp_a.push_back(16'h5AC3);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!a_if.busy) break;
      a_if.start   = 1'b1;
      a_if.tx_data = ~a_if.tx_data;
    end
    a_if.start = 1'b0;
    check("storm_idle", a_if.busy, 1'b0);
    send_a(16'h0FF0, 16'h0FF0);

    // Abort mid-frame in the 5th sclk-high phase.
    mon_en     = 1'b0;
    saved_done = a_done_total;
    @(negedge clk);
    a_if.start   = 1'b1;
    a_if.tx_data = 16'hFFFF;
    @(negedge clk);
    a_if.start = 1'b0;
    rises      = 0;
    sclk_seen  = a_if.sclk;
    for (int i = 0; i < 400; i++) begin
      if (a_if.sclk && !sclk_seen) rises++;
      sclk_seen = a_if.sclk;
      if (rises == 5) break;
      @(negedge clk);
    end
    check("abort_reached_5th_high", rises, 5);
    rst = 1'b1;
    @(negedge clk);
    check("abort_cs", a_if.cs, 1'b1);
    check("abort_sclk", a_if.sclk, 1'b0);
    check("abort_mosi", a_if.mosi, 1'b0);
    check("abort_busy", a_if.busy, 1'b0);
    check("abort_rx_data", a_if.rx_data, 0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("abort_no_done", a_done_total, saved_done);

    // rst and start together: start is dropped.
    rst = 1'b1;
    a_if.start   = 1'b1;
    a_if.tx_data = 16'hBEEF;
    @(negedge clk);
    rst = 1'b0;
    a_if.start = 1'b0;
    check("rst_start_busy", a_if.busy, 1'b0);
    @(negedge clk);
    check("rst_start_busy_after", a_if.busy, 1'b0);
    check("rst_start_cs", a_if.cs, 1'b1);

    mon_en = 1'b1;
    send_a(16'h1234, 16'h1234);

    // CLK_DIV=2 back-to-back frames.
    @(negedge clk);
    b_if.start   = 1'b1;
    b_if.tx_data = 16'hFFFF;
    exp_b.push_back(16'hFFFF);
    @(negedge clk);
    b_if.start = 1'b0;
    wait_idle_b();
    b_if.start   = 1'b1;
    b_if.tx_data = 16'h0000;
    exp_b.push_back(16'h0000);
    @(negedge clk);
    b_if.start = 1'b0;
    check("b_second_accepted", b_if.busy, 1'b1);
    wait_idle_b();
    repeat (4) @(negedge clk);

    check("a_sb_drained", exp_a.size(), 0);
    check("b_sb_drained", exp_b.size(), 0);
    check("b_frame_count", b_frames, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
